// File: rtl/cart_detect.sv
// Cartridge-type detector: snoops the ioctl ROM download, sizes the image and
// counts bankswitch hot-spot signatures, then picks force_bs/sc at download end.
module cart_detect #(
  parameter int SC_SPAN = 128,
  parameter int CNT_W   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [3:0]  ext_bs,
  input  logic        ext_sc,
  input  logic [1:0]  sc_mode,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        det_valid
);
  typedef enum logic [1:0] {IDLE, LOAD, DECIDE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [16:0]      SC_LIM  = 17'(SC_SPAN);

  state_t           state, state_nxt;
  logic             old_dl, rise, fall, snoop, start;
  logic [16:0]      size, size_nxt, prev_addr;
  logic [17:0]      addr_p1;
  logic [7:0]       h2, h1, h0, n2, n1, n0, b0;
  logic             sc_flag;
  logic [CNT_W-1:0] e0_cnt, tf_cnt, fe_cnt;
  logic             hit_e0, hit_tf, hit_fe;
  logic [3:0]       bs_pick;
  logic             sc_pick;

  assign rise  = ioctl_download & ~old_dl;
  assign fall  = ~ioctl_download & old_dl;
  assign start = (state == IDLE || state == DONE) && rise;
  // The falling-edge cycle is still LOAD, so a coincident last byte is counted.
  assign snoop = (state == LOAD) && ioctl_wr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = LOAD;
      LOAD:    if (fall) state_nxt = DECIDE;
      DECIDE:  state_nxt = DONE;
      DONE:    if (rise) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Size tracking and history shift for the current write.
  always_comb begin
    addr_p1  = {1'b0, ioctl_addr} + 18'd1;
    size_nxt = size;
    if (addr_p1[17])               size_nxt = 17'h1FFFF;
    else if (addr_p1[16:0] > size) size_nxt = addr_p1[16:0];
    if (ioctl_addr == prev_addr + 17'd1) {n2, n1, n0} = {h1, h0, ioctl_dout};
    else                                 {n2, n1, n0} = {16'h0, ioctl_dout};
    hit_e0 = (n2 == 8'h8D || n2 == 8'hAD || n2 == 8'h2C) && n1[7:3] == 5'b11100 && n0 == 8'h1F;
    hit_tf = n1 == 8'h85 && n0 == 8'h3F;
    hit_fe = n2 == 8'h20 && n1 == 8'h00 && (n0 == 8'hD0 || n0 == 8'hF0);
  end

  always_comb begin
    bs_pick = 4'd0;
    if (ext_bs != 4'd0)                            bs_pick = ext_bs;
    else if (size == 17'd8192) begin
      if (e0_cnt >= CNT_W'(2))                     bs_pick = 4'd4;
      else if (tf_cnt != '0)                       bs_pick = 4'd5;
      else if (fe_cnt >= CNT_W'(2))                bs_pick = 4'd3;
      else                                         bs_pick = 4'd1;
    end
    else if (size >= 17'd10240 && size <= 17'd10495) bs_pick = 4'd7;
    else if (size == 17'd12288)                    bs_pick = 4'd8;
    else if (size == 17'd16384)                    bs_pick = (tf_cnt != '0) ? 4'd5 : 4'd2;
    else if (size == 17'd32768)                    bs_pick = (tf_cnt != '0) ? 4'd5 : 4'd6;
    else if (size <= 17'd4096)                     bs_pick = 4'd0;
    else                                           bs_pick = (tf_cnt != '0) ? 4'd5 : 4'd0;

    case (sc_mode)
      2'd0:    sc_pick = ext_sc | (sc_flag & (size >= 17'd8192) & (size >= SC_LIM));
      2'd1:    sc_pick = 1'b0;
      default: sc_pick = 1'b1;
    endcase
  end

  // old_dl follows the pin even in reset so a download still active across
  // reset is not mistaken for a fresh start.
  always_ff @(posedge clk_sys) old_dl <= ioctl_download;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      size      <= '0;
      prev_addr <= '0;
      {h2, h1, h0} <= '0;
      b0        <= '0;
      sc_flag   <= 1'b0;
      e0_cnt    <= '0;
      tf_cnt    <= '0;
      fe_cnt    <= '0;
      force_bs  <= '0;
      sc        <= 1'b0;
      rom_size  <= '0;
      det_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        size      <= '0;
        prev_addr <= '0;
        {h2, h1, h0} <= '0;
        b0        <= '0;
        sc_flag   <= 1'b1;
        e0_cnt    <= '0;
        tf_cnt    <= '0;
        fe_cnt    <= '0;
        force_bs  <= '0;
        sc        <= 1'b0;
        rom_size  <= '0;
        det_valid <= 1'b0;
      end else if (snoop) begin
        size      <= size_nxt;
        prev_addr <= ioctl_addr;
        {h2, h1, h0} <= {n2, n1, n0};
        if (ioctl_addr == 17'd0)                             b0 <= ioctl_dout;
        else if (ioctl_addr < SC_LIM && ioctl_dout != b0)    sc_flag <= 1'b0;
        if (hit_e0 && e0_cnt != CNT_MAX) e0_cnt <= e0_cnt + CNT_W'(1);
        if (hit_tf && tf_cnt != CNT_MAX) tf_cnt <= tf_cnt + CNT_W'(1);
        if (hit_fe && fe_cnt != CNT_MAX) fe_cnt <= fe_cnt + CNT_W'(1);
      end
      if (state == DECIDE) begin
        force_bs  <= bs_pick;
        sc        <= sc_pick;
        rom_size  <= size;
        det_valid <= 1'b1;
      end
    end
  end
endmodule
